// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the multi-cycle controller: opcode map, ALU codes, datapath selects, states.
// Pure definitions; no logic, latency or backpressure of its own.
package mc_ctrl_pkg;

  localparam logic [6:0] OP_R    = 7'd0;
  localparam logic [6:0] OP_LW   = 7'd1;
  localparam logic [6:0] OP_ADDI = 7'd2;
  localparam logic [6:0] OP_XORI = 7'd3;
  localparam logic [6:0] OP_ORI  = 7'd4;
  localparam logic [6:0] OP_SLTI = 7'd5;
  localparam logic [6:0] OP_JALR = 7'd6;
  localparam logic [6:0] OP_SW   = 7'd7;
  localparam logic [6:0] OP_JAL  = 7'd8;
  localparam logic [6:0] OP_BEQ  = 7'd9;
  localparam logic [6:0] OP_BNE  = 7'd10;
  localparam logic [6:0] OP_BLT  = 7'd11;
  localparam logic [6:0] OP_BGE  = 7'd12;
  localparam logic [6:0] OP_LUI  = 7'd13;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALU_OUT = 2'b00;
  localparam logic [1:0] RES_MDR     = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;
  localparam logic [1:0] RES_IMM     = 2'b11;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_EXEC_I  = 4'd3,
    S_ALU_WB  = 4'd4,
    S_MEM_ADR = 4'd5,
    S_MEM_RD  = 4'd6,
    S_MEM_WB  = 4'd7,
    S_MEM_WR  = 4'd8,
    S_BRANCH  = 4'd9,
    S_JAL     = 4'd10,
    S_JALR    = 4'd11,
    S_LUI     = 4'd12,
    S_TRAP    = 4'd13
  } state_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_sel;
    logic       ir_we;
    logic       pc_we;
    logic       reg_we;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [2:0] imm_sel;
    logic [1:0] result_sel;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_branch(input logic [6:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT) || (op == OP_BGE);
  endfunction

endpackage

// File: rtl/multi_cycle_controller_if.sv
// Control/status bundle between the multi-cycle controller (master) and its datapath/memory (slave).
// Plain wires; handshake semantics live in the controller.
interface multi_cycle_controller_if #(
  parameter int STATE_W = 4
);
  logic [6:0]         op;
  logic [2:0]         f3;
  logic               zero;
  logic               sign_bit;
  logic               mem_ready;
  logic               mem_req;
  logic               mem_we;
  logic               adr_sel;
  logic               ir_we;
  logic               pc_we;
  logic               reg_we;
  logic [1:0]         alu_src_a;
  logic [1:0]         alu_src_b;
  logic [2:0]         alu_op;
  logic [2:0]         imm_sel;
  logic [1:0]         result_sel;
  logic               illegal;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  op, f3, zero, sign_bit, mem_ready,
    output mem_req, mem_we, adr_sel, ir_we, pc_we, reg_we,
           alu_src_a, alu_src_b, alu_op, imm_sel, result_sel, illegal, state_o
  );

  modport slave (
    output op, f3, zero, sign_bit, mem_ready,
    input  mem_req, mem_we, adr_sel, ir_we, pc_we, reg_we,
           alu_src_a, alu_src_b, alu_op, imm_sel, result_sel, illegal, state_o
  );
endinterface

// File: rtl/multi_cycle_controller_next_state.sv
// Combinational next-state decoder for the multi-cycle controller; zero latency.
// Memory states hold until mem_ready; TRAP is absorbing until reset.
module mc_next_state
  import mc_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output state_e     state_d
);

  always_comb begin
    state_d = S_FETCH;
    case (state)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_R:                              state_d = S_EXEC_R;
          OP_ADDI, OP_XORI, OP_ORI, OP_SLTI: state_d = S_EXEC_I;
          OP_LW, OP_SW:                      state_d = S_MEM_ADR;
          OP_BEQ, OP_BNE, OP_BLT, OP_BGE:    state_d = S_BRANCH;
          OP_JAL:                            state_d = S_JAL;
          OP_JALR:                           state_d = S_JALR;
          OP_LUI:                            state_d = S_LUI;
          default:                           state_d = S_TRAP;
        endcase
      end
      S_EXEC_R:  state_d = S_ALU_WB;
      S_EXEC_I:  state_d = S_ALU_WB;
      S_MEM_ADR: state_d = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:  state_d = mem_ready ? S_FETCH : S_MEM_WR;
      S_TRAP:    state_d = S_TRAP;
      // Single-cycle writeback/jump states and the unused codes 14/15 all resume fetching.
      default:   state_d = S_FETCH;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle sequencer: 3-5 cycles per instruction plus one per memory stall cycle; Moore outputs.
// Memory requests hold address/selects stable until mem_ready; all outputs forced to 0 while rst is low.
module multi_cycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  multi_cycle_controller_if.master  bus
);
  import mc_ctrl_pkg::*;

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl_dec;
  ctrl_t  ctrl_out;

  mc_next_state u_next_state (
    .state     (state_q),
    .op        (bus.op),
    .mem_ready (bus.mem_ready),
    .state_d   (state_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    ctrl_dec = '0;
    case (state_q)
      S_FETCH: begin
        ctrl_dec.mem_req    = 1'b1;
        ctrl_dec.adr_sel    = 1'b0;
        ctrl_dec.alu_src_a  = SRC_A_PC;
        ctrl_dec.alu_src_b  = SRC_B_FOUR;
        ctrl_dec.alu_op     = ALU_ADD;
        ctrl_dec.result_sel = RES_ALU;
        ctrl_dec.ir_we      = bus.mem_ready;
        ctrl_dec.pc_we      = bus.mem_ready;
      end
      S_DECODE: begin
        // Speculatively form old_pc + imm so branch/JAL targets are ready in alu_out.
        ctrl_dec.alu_src_a = SRC_A_OLD_PC;
        ctrl_dec.alu_src_b = SRC_B_IMM;
        ctrl_dec.alu_op    = ALU_ADD;
        if (is_branch(bus.op)) begin
          ctrl_dec.imm_sel = IMM_B;
        end else if (bus.op == OP_JAL) begin
          ctrl_dec.imm_sel = IMM_J;
        end
      end
      S_EXEC_R: begin
        ctrl_dec.alu_src_a = SRC_A_RS1;
        ctrl_dec.alu_src_b = SRC_B_RS2;
        ctrl_dec.alu_op    = bus.f3;
      end
      S_EXEC_I: begin
        ctrl_dec.alu_src_a = SRC_A_RS1;
        ctrl_dec.alu_src_b = SRC_B_IMM;
        ctrl_dec.imm_sel   = IMM_I;
        case (bus.op)
          OP_XORI: ctrl_dec.alu_op = ALU_XOR;
          OP_ORI:  ctrl_dec.alu_op = ALU_OR;
          OP_SLTI: ctrl_dec.alu_op = ALU_SLT;
          default: ctrl_dec.alu_op = ALU_ADD;
        endcase
      end
      S_ALU_WB: begin
        ctrl_dec.reg_we     = 1'b1;
        ctrl_dec.result_sel = RES_ALU_OUT;
      end
      S_MEM_ADR: begin
        ctrl_dec.alu_src_a = SRC_A_RS1;
        ctrl_dec.alu_src_b = SRC_B_IMM;
        ctrl_dec.alu_op    = ALU_ADD;
        ctrl_dec.imm_sel   = (bus.op == OP_SW) ? IMM_S : IMM_I;
      end
      S_MEM_RD: begin
        ctrl_dec.mem_req = 1'b1;
        ctrl_dec.adr_sel = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_dec.reg_we     = 1'b1;
        ctrl_dec.result_sel = RES_MDR;
      end
      S_MEM_WR: begin
        ctrl_dec.mem_req = 1'b1;
        ctrl_dec.mem_we  = 1'b1;
        ctrl_dec.adr_sel = 1'b1;
      end
      S_BRANCH: begin
        ctrl_dec.alu_src_a  = SRC_A_RS1;
        ctrl_dec.alu_src_b  = SRC_B_RS2;
        ctrl_dec.alu_op     = ALU_SUB;
        ctrl_dec.result_sel = RES_ALU_OUT;
        case (bus.op)
          OP_BEQ:  ctrl_dec.pc_we = bus.zero;
          OP_BNE:  ctrl_dec.pc_we = ~bus.zero;
          OP_BLT:  ctrl_dec.pc_we = bus.sign_bit;
          OP_BGE:  ctrl_dec.pc_we = ~bus.sign_bit;
          default: ctrl_dec.pc_we = 1'b0;
        endcase
      end
      S_JAL: begin
        // Datapath steers the PC register into rd whenever pc_we and reg_we coincide.
        ctrl_dec.pc_we      = 1'b1;
        ctrl_dec.reg_we     = 1'b1;
        ctrl_dec.result_sel = RES_ALU_OUT;
      end
      S_JALR: begin
        ctrl_dec.pc_we      = 1'b1;
        ctrl_dec.reg_we     = 1'b1;
        ctrl_dec.alu_src_a  = SRC_A_RS1;
        ctrl_dec.alu_src_b  = SRC_B_IMM;
        ctrl_dec.imm_sel    = IMM_I;
        ctrl_dec.alu_op     = ALU_ADD;
        ctrl_dec.result_sel = RES_ALU;
      end
      S_LUI: begin
        ctrl_dec.reg_we     = 1'b1;
        ctrl_dec.imm_sel    = IMM_U;
        ctrl_dec.result_sel = RES_IMM;
      end
      S_TRAP: begin
        ctrl_dec.illegal = 1'b1;
      end
      default: begin
        ctrl_dec = '0;
      end
    endcase
  end

  // Reset gates the outputs combinationally so FETCH's mem_req cannot leak out during reset.
  assign ctrl_out = rst ? ctrl_dec : '0;

  assign bus.mem_req    = ctrl_out.mem_req;
  assign bus.mem_we     = ctrl_out.mem_we;
  assign bus.adr_sel    = ctrl_out.adr_sel;
  assign bus.ir_we      = ctrl_out.ir_we;
  assign bus.pc_we      = ctrl_out.pc_we;
  assign bus.reg_we     = ctrl_out.reg_we;
  assign bus.alu_src_a  = ctrl_out.alu_src_a;
  assign bus.alu_src_b  = ctrl_out.alu_src_b;
  assign bus.alu_op     = ctrl_out.alu_op;
  assign bus.imm_sel    = ctrl_out.imm_sel;
  assign bus.result_sel = ctrl_out.result_sel;
  assign bus.illegal    = ctrl_out.illegal;
  assign bus.state_o    = STATE_W'(state_q);

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Scoreboard bench for multi_cycle_controller: per-cycle stimulus and expected output vectors are queued together.
module tb_multi_cycle_controller;
  import mc_ctrl_pkg::*;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic       rdy;
    logic       z;
    logic       s;
  } stim_t;

  // {state, mem_req, mem_we, adr_sel, ir_we, pc_we, reg_we, src_a, src_b, alu_op, imm_sel, result_sel, illegal}
  typedef logic [22:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  multi_cycle_controller_if #(.STATE_W(4)) bus ();

  multi_cycle_controller #(.STATE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  stim_t stim_q[$];
  vec_t  exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic vec_t e(input logic [3:0] st, input logic req, we, adr, irw, pcw, rw,
                             input logic [1:0] sa, sb, input logic [2:0] aop, imm,
                             input logic [1:0] rs, input logic ill);
    return {st, req, we, adr, irw, pcw, rw, sa, sb, aop, imm, rs, ill};
  endfunction

  function automatic vec_t fetch_v(input logic rdy);
    return e(4'd0, 1'b1, 1'b0, 1'b0, rdy, rdy, 1'b0, 2'd0, 2'd2, 3'd0, 3'd0, 2'd2, 1'b0);
  endfunction

  function automatic vec_t decode_v(input logic [2:0] imm);
    return e(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 3'd0, imm, 2'd0, 1'b0);
  endfunction

  function automatic vec_t obs();
    return {bus.state_o, bus.mem_req, bus.mem_we, bus.adr_sel, bus.ir_we, bus.pc_we, bus.reg_we,
            bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.imm_sel, bus.result_sel, bus.illegal};
  endfunction

  task automatic push(input logic [6:0] op, input logic [2:0] f3, input logic rdy, z, s, input vec_t v);
    stim_q.push_back({op, f3, rdy, z, s});
    exp_q.push_back(v);
  endtask

  task automatic apply(input stim_t s);
    @(negedge clk);
    bus.op        = s.op;
    bus.f3        = s.f3;
    bus.mem_ready = s.rdy;
    bus.zero      = s.z;
    bus.sign_bit  = s.s;
    #1;
  endtask

  task automatic test_reset();
    vec_t got;
    vec_t want;
    int   cyc;
    rst = 1'b0;
    bus.op = OP_LW; bus.f3 = 3'd0; bus.zero = 1'b0; bus.sign_bit = 1'b0; bus.mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.mem_ready = 1'(i);
      #1;
      got = obs(); n_cmp++;
      if (got !== '0) begin
        n_bad++; $display("FAIL reset_hold %0d: got %h required 0", i, got);
      end
    end
    @(negedge clk);
    rst = 1'b1; bus.mem_ready = 1'b0;
    #1;
    got = obs(); want = fetch_v(1'b0); n_cmp++;
    if (got !== want) begin
      n_bad++; $display("FAIL reset_release: got %h required %h", got, want);
    end
    push(OP_LW, 3'd0, 1'b1, 1'b0, 1'b0, fetch_v(1'b1));
    push(OP_LW, 3'd0, 1'b1, 1'b0, 1'b0, decode_v(IMM_I));
    push(OP_LW, 3'd0, 1'b1, 1'b0, 1'b0, e(4'd5, 0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 3'd0, 3'd0, 2'd0, 0));
    push(OP_LW, 3'd0, 1'b0, 1'b0, 1'b0, e(4'd6, 1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 3'd0, 3'd0, 2'd0, 0));
    cyc = 0;
    while (exp_q.size() > 0) begin
      apply(stim_q.pop_front());
      want = exp_q.pop_front(); got = obs(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL reset_lw cyc%0d: got %h required %h", cyc, got, want);
      end
      cyc++;
    end
    #2 rst = 1'b0;
    #1;
    got = obs(); n_cmp++;
    if (got !== '0) begin
      n_bad++; $display("FAIL async_reset_mid_mem_rd: got %h required 0", got);
    end
    @(negedge clk);
    bus.mem_ready = 1'b1;
    #1;
    got = obs(); n_cmp++;
    if (got !== '0) begin
      n_bad++; $display("FAIL reset_held_ready: got %h required 0", got);
    end
    @(negedge clk);
    rst = 1'b1; bus.mem_ready = 1'b0;
    #1;
    got = obs(); want = fetch_v(1'b0); n_cmp++;
    if (got !== want) begin
      n_bad++; $display("FAIL post_reset_fetch: got %h required %h", got, want);
    end
  endtask

  task automatic test_r_type();
    vec_t got;
    vec_t want;
    int   cyc;
    logic [2:0] f3_tab [2];
    f3_tab[0] = 3'b100;
    f3_tab[1] = 3'b001;
    for (int i = 0; i < 2; i++) begin
      push(OP_R, f3_tab[i], 1'b1, 1'b0, 1'b0, fetch_v(1'b1));
      push(OP_R, f3_tab[i], 1'b1, 1'b0, 1'b0, decode_v(IMM_I));
      push(OP_R, f3_tab[i], 1'b1, 1'b0, 1'b0, e(4'd2, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, f3_tab[i], 3'd0, 2'd0, 0));
      push(OP_R, f3_tab[i], 1'b1, 1'b0, 1'b0, e(4'd4, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 3'd0, 3'd0, 2'd0, 0));
    end
    push(OP_R, 3'd0, 1'b0, 1'b0, 1'b0, fetch_v(1'b0));
    cyc = 0;
    while (exp_q.size() > 0) begin
      apply(stim_q.pop_front());
      want = exp_q.pop_front(); got = obs(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL r_type cyc%0d: got %h required %h", cyc, got, want);
      end
      cyc++;
    end
  endtask

  task automatic test_back_to_back_imm();
    vec_t got;
    vec_t want;
    int   cyc;
    logic [6:0] op_tab  [4];
    logic [2:0] alu_tab [4];
    op_tab[0] = OP_ADDI; alu_tab[0] = 3'b000;
    op_tab[1] = OP_XORI; alu_tab[1] = 3'b100;
    op_tab[2] = OP_ORI;  alu_tab[2] = 3'b110;
    op_tab[3] = OP_SLTI; alu_tab[3] = 3'b101;
    for (int i = 0; i < 4; i++) begin
      push(op_tab[i], 3'd7, 1'b1, 1'b0, 1'b0, fetch_v(1'b1));
      push(op_tab[i], 3'd7, 1'b1, 1'b0, 1'b0, decode_v(IMM_I));
      push(op_tab[i], 3'd7, 1'b1, 1'b0, 1'b0, e(4'd3, 0, 0, 0, 0, 0, 0, 2'd2, 2'd1, alu_tab[i], 3'd0, 2'd0, 0));
      push(op_tab[i], 3'd7, 1'b1, 1'b0, 1'b0, e(4'd4, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 3'd0, 3'd0, 2'd0, 0));
    end
    push(OP_ADDI, 3'd0, 1'b0, 1'b0, 1'b0, fetch_v(1'b0));
    cyc = 0;
    while (exp_q.size() > 0) begin
      apply(stim_q.pop_front());
      want = exp_q.pop_front(); got = obs(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL imm_b2b cyc%0d: got %h required %h", cyc, got, want);
      end
      cyc++;
    end
  endtask

  task automatic test_lw_stall();
    vec_t got;
    vec_t want;
    int   cyc;
    push(OP_LW, 3'd0, 1'b0, 1'b0, 1'b0, fetch_v(1'b0));
    push(OP_LW, 3'd0, 1'b0, 1'b0, 1'b0, fetch_v(1'b0));
    push(OP_LW, 3'd0, 1'b1, 1'b0, 1'b0, fetch_v(1'b1));
    push(OP_LW, 3'd0, 1'b1, 1'b0, 1'b0, decode_v(IMM_I));
    push(OP_LW, 3'd0, 1'b1, 1'b0, 1'b0, e(4'd5, 0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 3'd0, 3'd0, 2'd0, 0));
    push(OP_LW, 3'd0, 1'b0, 1'b0, 1'b0, e(4'd6, 1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 3'd0, 3'd0, 2'd0, 0));
    push(OP_LW, 3'd0, 1'b0, 1'b0, 1'b0, e(4'd6, 1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 3'd0, 3'd0, 2'd0, 0));
    push(OP_LW, 3'd0, 1'b1, 1'b0, 1'b0, e(4'd6, 1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 3'd0, 3'd0, 2'd0, 0));
    push(OP_LW, 3'd0, 1'b1, 1'b0, 1'b0, e(4'd7, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 3'd0, 3'd0, 2'd1, 0));
    push(OP_LW, 3'd0, 1'b0, 1'b0, 1'b0, fetch_v(1'b0));
    cyc = 0;
    while (exp_q.size() > 0) begin
      apply(stim_q.pop_front());
      want = exp_q.pop_front(); got = obs(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL lw_stall cyc%0d: got %h required %h", cyc, got, want);
      end
      cyc++;
    end
  endtask

  task automatic test_branch();
    vec_t got;
    vec_t want;
    int   cyc;
    logic [6:0] op_tab [8];
    logic [2:0] zst_tab [8];
    op_tab[0] = OP_BNE; zst_tab[0] = 3'b100;
    op_tab[1] = OP_BNE; zst_tab[1] = 3'b001;
    op_tab[2] = OP_BGE; zst_tab[2] = 3'b001;
    op_tab[3] = OP_BGE; zst_tab[3] = 3'b010;
    op_tab[4] = OP_BEQ; zst_tab[4] = 3'b101;
    op_tab[5] = OP_BEQ; zst_tab[5] = 3'b010;
    op_tab[6] = OP_BLT; zst_tab[6] = 3'b011;
    op_tab[7] = OP_BLT; zst_tab[7] = 3'b100;
    for (int i = 0; i < 8; i++) begin
      push(op_tab[i], 3'd0, 1'b1, 1'b0, 1'b0, fetch_v(1'b1));
      push(op_tab[i], 3'd0, 1'b1, 1'b0, 1'b0, decode_v(IMM_B));
      push(op_tab[i], 3'd0, 1'b1, zst_tab[i][2], zst_tab[i][1],
           e(4'd9, 0, 0, 0, 0, zst_tab[i][0], 0, 2'd2, 2'd0, 3'd1, 3'd0, 2'd0, 0));
    end
    push(OP_BEQ, 3'd0, 1'b0, 1'b0, 1'b0, fetch_v(1'b0));
    cyc = 0;
    while (exp_q.size() > 0) begin
      apply(stim_q.pop_front());
      want = exp_q.pop_front(); got = obs(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL branch cyc%0d: got %h required %h", cyc, got, want);
      end
      cyc++;
    end
  endtask

  task automatic test_sw();
    vec_t got;
    vec_t want;
    int   cyc;
    push(OP_SW, 3'd2, 1'b1, 1'b0, 1'b0, fetch_v(1'b1));
    push(OP_SW, 3'd2, 1'b1, 1'b0, 1'b0, decode_v(IMM_I));
    push(OP_SW, 3'd2, 1'b1, 1'b0, 1'b0, e(4'd5, 0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 3'd0, 3'd1, 2'd0, 0));
    push(OP_SW, 3'd2, 1'b1, 1'b0, 1'b0, e(4'd8, 1, 1, 1, 0, 0, 0, 2'd0, 2'd0, 3'd0, 3'd0, 2'd0, 0));
    push(OP_SW, 3'd2, 1'b0, 1'b0, 1'b0, fetch_v(1'b0));
    cyc = 0;
    while (exp_q.size() > 0) begin
      apply(stim_q.pop_front());
      want = exp_q.pop_front(); got = obs(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL sw cyc%0d: got %h required %h", cyc, got, want);
      end
      cyc++;
    end
  endtask

  task automatic test_jumps();
    vec_t got;
    vec_t want;
    int   cyc;
    push(OP_JAL, 3'd0, 1'b1, 1'b0, 1'b0, fetch_v(1'b1));
    push(OP_JAL, 3'd0, 1'b1, 1'b0, 1'b0, decode_v(IMM_J));
    push(OP_JAL, 3'd0, 1'b1, 1'b0, 1'b0, e(4'd10, 0, 0, 0, 0, 1, 1, 2'd0, 2'd0, 3'd0, 3'd0, 2'd0, 0));
    push(OP_JALR, 3'd0, 1'b1, 1'b0, 1'b0, fetch_v(1'b1));
    push(OP_JALR, 3'd0, 1'b1, 1'b0, 1'b0, decode_v(IMM_I));
    push(OP_JALR, 3'd0, 1'b1, 1'b0, 1'b0, e(4'd11, 0, 0, 0, 0, 1, 1, 2'd2, 2'd1, 3'd0, 3'd0, 2'd2, 0));
    push(OP_LUI, 3'd0, 1'b1, 1'b0, 1'b0, fetch_v(1'b1));
    push(OP_LUI, 3'd0, 1'b1, 1'b0, 1'b0, decode_v(IMM_I));
    push(OP_LUI, 3'd0, 1'b1, 1'b0, 1'b0, e(4'd12, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 3'd0, 3'd4, 2'd3, 0));
    push(OP_LUI, 3'd0, 1'b0, 1'b0, 1'b0, fetch_v(1'b0));
    cyc = 0;
    while (exp_q.size() > 0) begin
      apply(stim_q.pop_front());
      want = exp_q.pop_front(); got = obs(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL jumps cyc%0d: got %h required %h", cyc, got, want);
      end
      cyc++;
    end
  endtask

  task automatic test_illegal();
    vec_t got;
    vec_t want;
    int   cyc;
    logic [6:0] op_tab [2];
    op_tab[0] = 7'd14;
    op_tab[1] = 7'h7F;
    for (int i = 0; i < 2; i++) begin
      push(op_tab[i], 3'd0, 1'b1, 1'b0, 1'b0, fetch_v(1'b1));
      push(op_tab[i], 3'd0, 1'b1, 1'b0, 1'b0, decode_v(IMM_I));
      for (int k = 0; k < 10; k++) begin
        push(op_tab[i], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), e(4'd13, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0, 3'd0, 2'd0, 1));
      end
      cyc = 0;
      while (exp_q.size() > 0) begin
        apply(stim_q.pop_front());
        want = exp_q.pop_front(); got = obs(); n_cmp++;
        if (got !== want) begin
          n_bad++; $display("FAIL illegal op%0d cyc%0d: got %h required %h", op_tab[i], cyc, got, want);
        end
        cyc++;
      end
      #2 rst = 1'b0;
      #1;
      got = obs(); n_cmp++;
      if (got !== '0) begin
        n_bad++; $display("FAIL trap_reset op%0d: got %h required 0", op_tab[i], got);
      end
      @(negedge clk);
      rst = 1'b1; bus.mem_ready = 1'b0;
      #1;
      got = obs(); want = fetch_v(1'b0); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL trap_exit op%0d: got %h required %h", op_tab[i], got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_back_to_back_imm();
    test_lw_stall();
    test_branch();
    test_sw();
    test_jumps();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/multi_cycle_controller.md
Name: multi_cycle_controller

Overview:
- Multi-cycle sequencer for the RV32-subset core using the team's custom 7-bit opcode map.
- Replaces per-instruction combinational decode with an FSM, so one shared memory port serves both fetch and data, and one ALU is time-shared.
- Sits beside the multi-cycle datapath. The datapath holds the IR, old_pc, alu_out and MDR registers; this block drives their write enables and all selects.
- Shared memory handshakes via mem_req/mem_ready.

Parameters:
- STATE_W, 4, width of state register and state_o

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- op  in  7  opcode from IR
- f3  in  3  funct3 from IR
- zero  in  1  ALU result == 0
- sign_bit  in  1  ALU result [31]
- mem_ready  in  1  memory accepted/completed the current access
- mem_req  out  1  memory access request
- mem_we  out  1  memory write
- adr_sel  out  1  0 = PC, 1 = alu_out as memory address
- ir_we  out  1  load IR and old_pc
- pc_we  out  1  load PC
- reg_we  out  1  register file write
- alu_src_a  out  2  00 PC, 01 old_pc, 10 rs1
- alu_src_b  out  2  00 rs2, 01 imm, 10 const 4
- alu_op  out  3  ALU function
- imm_sel  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- result_sel  out  2  00 alu_out, 01 MDR, 10 ALU result, 11 imm
- illegal  out  1  undefined opcode trapped
- state_o  out  STATE_W  current state, debug only

Behaviour:
- Reset: rst low forces FETCH immediately, including mid-instruction. All outputs are 0 while rst is low; state_o = 0.
- Outputs are Moore functions of state, except:
  - FETCH/MEM_RD/MEM_WR write enables are qualified by mem_ready.
  - BRANCH pc_we is qualified by zero/sign_bit.
- Unlisted outputs are 0; don't-care selects drive 0.
- Opcodes: R 0, LW 1, ADDI 2, XORI 3, ORI 4, SLTI 5, JALR 6, SW 7, JAL 8, BEQ 9, BNE 10, BLT 11, BGE 12, LUI 13. Anything else is illegal.
- ALU codes: ADD 000, SUB 001, XOR 100, OR 110, SLT 101. R-type passes f3.
- FETCH(0):
  - Outputs: mem_req=1, adr_sel=0, alu_src_a=00, alu_src_b=10, alu_op=ADD.
  - On mem_ready: ir_we=1, pc_we=1 (result_sel=10), go to DECODE.
  - Otherwise hold (stall, no enables).
- DECODE(1):
  - Outputs: alu_src_a=01, alu_src_b=01, imm_sel from op (B or J), alu_op=ADD. This precomputes the target into alu_out.
  - Next: R→EXEC_R; ADDI/XORI/ORI/SLTI→EXEC_I; LW/SW→MEM_ADR; BEQ..BGE→BRANCH; JAL→JAL; JALR→JALR; LUI→LUI; else→TRAP.
- EXEC_R(2): src_a=10, src_b=00, alu_op=f3 → ALU_WB.
- EXEC_I(3): src_a=10, src_b=01, imm_sel=I, alu_op ADD/XOR/OR/SLT per op → ALU_WB.
- ALU_WB(4): reg_we=1, result_sel=00 → FETCH.
- MEM_ADR(5): src_a=10, src_b=01, imm_sel I (LW) or S (SW), ADD → MEM_RD (LW) or MEM_WR (SW).
- MEM_RD(6): mem_req=1, adr_sel=1; on mem_ready → MEM_WB, else hold.
- MEM_WB(7): reg_we=1, result_sel=01 → FETCH.
- MEM_WR(8): mem_req=1, mem_we=1, adr_sel=1; on mem_ready → FETCH, else hold.
- BRANCH(9): src_a=10, src_b=00, alu_op=SUB, result_sel=00; then → FETCH.
  - pc_we = (BEQ & zero) | (BNE & ~zero) | (BLT & sign_bit) | (BGE & ~sign_bit).
- JAL(10): pc_we=1 with result_sel=00 (target). reg_we=1 writes PC+4: src_a=00, src_b=10? no, PC already +4, so use src_a=00, src_b=01, imm_sel=U zeroed? No — use result_sel per write: pc takes alu_out, rd takes PC via ALU (src_a=00, alu_op=ADD, src_b=00 with rs2 ignored is invalid). The datapath routes rd write data from the PC register when pc_we & reg_we are both set in JAL/JALR. → FETCH.
- JALR(11): src_a=10, src_b=01, imm_sel=I, ADD, result_sel=10 into PC; reg_we=1 writes old PC value (same datapath rule) → FETCH.
- LUI(12): reg_we=1, imm_sel=U, result_sel=11 → FETCH.
- TRAP(13): illegal=1, all enables 0, stays until reset.
- Minimum latency in cycles:
  - R/I: 4
  - LW: 5
  - SW: 4
  - Branch, JAL, JALR, LUI: 3
  - Each memory stall cycle adds 1.
- Memory handshake:
  - mem_ready is ignored when mem_req=0.
  - mem_req stays high, with address/select stable, until mem_ready.
- Unreachable state codes 14/15 go to FETCH.

Decomposition:
- Package mc_ctrl_pkg holds the opcode constants, ALU codes, imm_sel/result_sel/src encodings and the state enum.
- One sub-module, mc_next_state: a combinational next-state decoder keyed on state/op/mem_ready. The registered state and output decode stay in the top.

Test Plan:
- Async reset mid-MEM_RD: rst low → state_o=0, all outputs 0 immediately. After release, FETCH asserts mem_req=1.
- R-type op=0, f3=100, mem_ready tied 1: states 0,1,2,4,0. alu_op=100 in EXEC_R; reg_we=1 only in ALU_WB.
- LW op=1 with mem_ready low 2 cycles in FETCH and in MEM_RD: mem_req held, no ir_we/reg_we until ready. Total 9 cycles; reg_we with result_sel=01.
- BNE op=10: zero=1 → pc_we=0 in BRANCH; zero=0 → pc_we=1. BGE op=12: sign_bit=0 → pc_we=1.
- SW op=7: MEM_WR asserts mem_req=mem_we=adr_sel=1, reg_we never asserts; returns to FETCH on mem_ready.
- Illegal op=0x7F: DECODE→TRAP, illegal=1 held 10 cycles with no enables; cleared only by rst low.
